// File: rtl/fb_write_arbiter.sv
// ============================================================================
// Module      : fb_write_arbiter
// Description : Frame-buffer write-port arbiter (camera vs. overlay) with
//               tear-free double-buffer bank sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_write_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int FB_SIZE    = 307200,
    parameter int MAX_STARVE = 15
) (
    input  logic              clk_25mhz,
    input  logic              rst_n,
    input  logic              cam_valid,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_data,
    output logic              cam_ready,
    input  logic              ovl_valid,
    input  logic [ADDR_W-1:0] ovl_addr,
    input  logic [DATA_W-1:0] ovl_data,
    output logic              ovl_ready,
    input  logic              cam_frame_done,
    input  logic              vga_frame_start,
    output logic              fb_we,
    output logic [ADDR_W:0]   fb_addr,
    output logic [DATA_W-1:0] fb_wdata,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              swap_pending,
    output logic [7:0]        drop_cnt,
    output logic              addr_err
);

    localparam int STARVE_W = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
    localparam logic [ADDR_W:0]     c_fb_limit   = (ADDR_W + 1)'(FB_SIZE);
    localparam logic [STARVE_W-1:0] c_max_starve = STARVE_W'(MAX_STARVE);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } bank_state_t;

    bank_state_t         state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                wr_bank_q, wr_bank_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic                addr_err_q, addr_err_d;
    logic                fb_we_q, fb_we_d;
    logic [ADDR_W:0]     fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0]   fb_wdata_q, fb_wdata_d;

    logic                w_cam_grant;
    logic                w_ovl_grant;
    logic                w_accept;
    logic                w_addr_ok;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_drop;

    // Camera has priority unless the overlay has waited MAX_STARVE cycles.
    always_comb begin
        w_ovl_grant = ovl_valid && (!cam_valid || (starve_q == c_max_starve));
        w_cam_grant = cam_valid && !w_ovl_grant;
        starve_d    = (ovl_valid && !w_ovl_grant) ? starve_q + STARVE_W'(1) : '0;
        w_sel_addr  = w_ovl_grant ? ovl_addr : cam_addr;
        w_sel_data  = w_ovl_grant ? ovl_data : cam_data;
        w_accept    = w_cam_grant || w_ovl_grant;
        w_addr_ok   = ({1'b0, w_sel_addr} < c_fb_limit);
    end

    // Write pipeline: illegal addresses complete the handshake but never reach BRAM.
    always_comb begin
        fb_we_d    = w_accept && w_addr_ok;
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;
        addr_err_d = addr_err_q || (w_accept && !w_addr_ok);
        if (fb_we_d) begin
            fb_addr_d  = {wr_bank_q, w_sel_addr};
            fb_wdata_d = w_sel_data;
        end
    end

    // Bank FSM: a finished frame waits for scan-out to reach (0,0) before swapping.
    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        w_drop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cam_frame_done) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                w_drop = cam_frame_done;
                if (vga_frame_start) begin
                    wr_bank_d = ~wr_bank_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        drop_cnt_d = (w_drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            wr_bank_q  <= 1'b0;
            drop_cnt_q <= 8'd0;
            addr_err_q <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            wr_bank_q  <= wr_bank_d;
            drop_cnt_q <= drop_cnt_d;
            addr_err_q <= addr_err_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_wdata_q <= fb_wdata_d;
        end
    end

    assign cam_ready    = w_cam_grant;
    assign ovl_ready    = w_ovl_grant;
    assign fb_we        = fb_we_q;
    assign fb_addr      = fb_addr_q;
    assign fb_wdata     = fb_wdata_q;
    assign wr_bank      = wr_bank_q;
    assign rd_bank      = ~wr_bank_q;
    assign swap_pending = (state_q == ST_PENDING);
    assign drop_cnt     = drop_cnt_q;
    assign addr_err     = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
// ============================================================================
// Module      : tb_fb_write_arbiter
// Description : Directed self-checking bench for fb_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_write_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 12;

    logic              clk_25mhz = 1'b0;
    logic              rst_n;
    logic              cam_valid;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_data;
    logic              cam_ready;
    logic              ovl_valid;
    logic [ADDR_W-1:0] ovl_addr;
    logic [DATA_W-1:0] ovl_data;
    logic              ovl_ready;
    logic              cam_frame_done;
    logic              vga_frame_start;
    logic              fb_we;
    logic [ADDR_W:0]   fb_addr;
    logic [DATA_W-1:0] fb_wdata;
    logic              wr_bank;
    logic              rd_bank;
    logic              swap_pending;
    logic [7:0]        drop_cnt;
    logic              addr_err;

    int checks = 0;
    int errors = 0;

    always #5 clk_25mhz = ~clk_25mhz;

    fb_write_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FB_SIZE    (307200),
        .MAX_STARVE (15)
    ) dut (
        .clk_25mhz       (clk_25mhz),
        .rst_n           (rst_n),
        .cam_valid       (cam_valid),
        .cam_addr        (cam_addr),
        .cam_data        (cam_data),
        .cam_ready       (cam_ready),
        .ovl_valid       (ovl_valid),
        .ovl_addr        (ovl_addr),
        .ovl_data        (ovl_data),
        .ovl_ready       (ovl_ready),
        .cam_frame_done  (cam_frame_done),
        .vga_frame_start (vga_frame_start),
        .fb_we           (fb_we),
        .fb_addr         (fb_addr),
        .fb_wdata        (fb_wdata),
        .wr_bank         (wr_bank),
        .rd_bank         (rd_bank),
        .swap_pending    (swap_pending),
        .drop_cnt        (drop_cnt),
        .addr_err        (addr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".fb_we"},        32'(fb_we),        32'd0);
        chk({tag, ".fb_addr"},      32'(fb_addr),      32'd0);
        chk({tag, ".fb_wdata"},     32'(fb_wdata),     32'd0);
        chk({tag, ".wr_bank"},      32'(wr_bank),      32'd0);
        chk({tag, ".rd_bank"},      32'(rd_bank),      32'd1);
        chk({tag, ".swap_pending"}, 32'(swap_pending), 32'd0);
        chk({tag, ".drop_cnt"},     32'(drop_cnt),     32'd0);
        chk({tag, ".addr_err"},     32'(addr_err),     32'd0);
    endtask

    initial begin
        int  st;
        bit  ov, exp_ovl;
        logic [31:0] exp_addr;

        rst_n = 1'b0; cam_valid = 1'b0; cam_addr = '0; cam_data = '0;
        ovl_valid = 1'b0; ovl_addr = '0; ovl_data = '0;
        cam_frame_done = 1'b0; vga_frame_start = 1'b0;

        // Reset values before any clock edge
        #3;
        chk_reset_values("por");
        @(negedge clk_25mhz); rst_n = 1'b1;
        tick();

        // Reset in the middle of a write
        cam_valid = 1'b1; cam_addr = 19'd5; cam_data = 12'hABC;
        @(negedge clk_25mhz);
        chk("t1.cam_ready", 32'(cam_ready), 32'd1);
        chk("t1.ovl_ready", 32'(ovl_ready), 32'd0);
        tick();
        chk("t1.fb_we",    32'(fb_we),    32'd1);
        chk("t1.fb_addr",  32'(fb_addr),  32'd5);
        chk("t1.fb_wdata", 32'(fb_wdata), 32'hABC);
        cam_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_values("t1.rst");
        @(negedge clk_25mhz); rst_n = 1'b1;
        tick();

        // Starvation guard: cam always valid, ovl valid except one cycle (i==37)
        cam_addr = 19'd1; cam_data = 12'h111;
        ovl_addr = 19'd2; ovl_data = 12'h222;
        st = 0;
        for (int i = 0; i < 64; i++) begin
            ov = (i != 37);
            cam_valid = 1'b1; ovl_valid = ov;
            exp_ovl = ov && (st == 15);
            @(negedge clk_25mhz);
            chk($sformatf("t2.ovl_ready[%0d]", i), 32'(ovl_ready), 32'(exp_ovl));
            chk($sformatf("t2.cam_ready[%0d]", i), 32'(cam_ready), 32'(!exp_ovl));
            tick();
            exp_addr = exp_ovl ? 32'd2 : 32'd1;
            chk($sformatf("t2.fb_we[%0d]", i),    32'(fb_we),    32'd1);
            chk($sformatf("t2.fb_addr[%0d]", i),  32'(fb_addr),  exp_addr);
            chk($sformatf("t2.fb_wdata[%0d]", i), 32'(fb_wdata), exp_ovl ? 32'h222 : 32'h111);
            st = (ov && !exp_ovl) ? st + 1 : 0;
        end
        cam_valid = 1'b0; ovl_valid = 1'b0;
        @(negedge clk_25mhz);
        chk("t2.idle.cam_ready", 32'(cam_ready), 32'd0);
        chk("t2.idle.ovl_ready", 32'(ovl_ready), 32'd0);
        tick();
        chk("t2.idle.fb_we",   32'(fb_we),   32'd0);
        chk("t2.idle.fb_addr", 32'(fb_addr), 32'd1);
        ovl_valid = 1'b1;
        @(negedge clk_25mhz);
        chk("t2.solo.ovl_ready", 32'(ovl_ready), 32'd1);
        chk("t2.solo.cam_ready", 32'(cam_ready), 32'd0);
        tick();
        ovl_valid = 1'b0;
        chk("t2.solo.fb_addr", 32'(fb_addr), 32'd2);

        // Address boundary: last legal pixel, then first illegal one
        cam_valid = 1'b1; cam_addr = 19'd307199; cam_data = 12'h0F0;
        tick();
        chk("t3.last.fb_we",    32'(fb_we),    32'd1);
        chk("t3.last.fb_addr",  32'(fb_addr),  32'd307199);
        chk("t3.last.addr_err", 32'(addr_err), 32'd0);
        cam_addr = 19'd307200; cam_data = 12'hFFF;
        @(negedge clk_25mhz);
        chk("t3.bad.cam_ready", 32'(cam_ready), 32'd1);
        tick();
        cam_valid = 1'b0;
        chk("t3.bad.fb_we",    32'(fb_we),    32'd0);
        chk("t3.bad.addr_err", 32'(addr_err), 32'd1);
        chk("t3.bad.fb_addr",  32'(fb_addr),  32'd307199);
        chk("t3.bad.fb_wdata", 32'(fb_wdata), 32'h0F0);
        repeat (3) tick();
        chk("t3.sticky.addr_err", 32'(addr_err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t3.rst.addr_err", 32'(addr_err), 32'd0);
        @(negedge clk_25mhz); rst_n = 1'b1;
        tick();

        // Frame done, swap ten cycles later
        cam_frame_done = 1'b1;
        tick();
        cam_frame_done = 1'b0;
        chk("t4.sp[0]", 32'(swap_pending), 32'd1);
        for (int k = 1; k < 10; k++) begin
            tick();
            chk($sformatf("t4.sp[%0d]", k), 32'(swap_pending), 32'd1);
            chk($sformatf("t4.wr_bank[%0d]", k), 32'(wr_bank), 32'd0);
        end
        vga_frame_start = 1'b1;
        tick();
        vga_frame_start = 1'b0;
        chk("t4.swap.wr_bank", 32'(wr_bank),      32'd1);
        chk("t4.swap.rd_bank", 32'(rd_bank),      32'd0);
        chk("t4.swap.sp",      32'(swap_pending), 32'd0);

        // Overwritten frame, then coincident pulses while pending
        cam_frame_done = 1'b1; tick(); cam_frame_done = 1'b0;
        chk("t5.sp", 32'(swap_pending), 32'd1);
        cam_frame_done = 1'b1; tick(); cam_frame_done = 1'b0;
        chk("t5.drop1",    32'(drop_cnt),     32'd1);
        chk("t5.wr_bank1", 32'(wr_bank),      32'd1);
        chk("t5.sp1",      32'(swap_pending), 32'd1);
        cam_frame_done = 1'b1; vga_frame_start = 1'b1; tick();
        chk("t5.both.drop",    32'(drop_cnt),     32'd2);
        chk("t5.both.wr_bank", 32'(wr_bank),      32'd0);
        chk("t5.both.rd_bank", 32'(rd_bank),      32'd1);
        chk("t5.both.sp",      32'(swap_pending), 32'd0);
        // Coincident pulses while idle only arm the swap
        tick();
        cam_frame_done = 1'b0; vga_frame_start = 1'b0;
        chk("t5.idleboth.sp",      32'(swap_pending), 32'd1);
        chk("t5.idleboth.wr_bank", 32'(wr_bank),      32'd0);
        chk("t5.idleboth.drop",    32'(drop_cnt),     32'd2);
        vga_frame_start = 1'b1; tick();
        chk("t5.swap2.wr_bank", 32'(wr_bank), 32'd1);
        tick(); vga_frame_start = 1'b0;
        chk("t5.vga_idle.wr_bank", 32'(wr_bank),      32'd1);
        chk("t5.vga_idle.sp",      32'(swap_pending), 32'd0);

        // Write accepted in the swapping cycle uses the old bank
        cam_frame_done = 1'b1; tick(); cam_frame_done = 1'b0;
        vga_frame_start = 1'b1;
        cam_valid = 1'b1; cam_addr = 19'h00123; cam_data = 12'h456;
        @(negedge clk_25mhz);
        chk("t6.cam_ready", 32'(cam_ready), 32'd1);
        tick();
        vga_frame_start = 1'b0; cam_valid = 1'b0;
        chk("t6.fb_we",    32'(fb_we),    32'd1);
        chk("t6.fb_addr",  32'(fb_addr),  32'h80123);
        chk("t6.fb_wdata", 32'(fb_wdata), 32'h456);
        chk("t6.wr_bank",  32'(wr_bank),  32'd0);

        // drop_cnt saturation: first pulse arms, each later one drops (2 + 299 -> 255)
        cam_frame_done = 1'b1;
        repeat (300) tick();
        cam_frame_done = 1'b0;
        chk("sat.drop_cnt", 32'(drop_cnt), 32'd255);
        chk("sat.wr_bank",  32'(wr_bank),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
